wbr_2: RTL and testbench

WBR_2 -- requirements
Module: wbr_2

---
 rtl/wbr_2_pkg.sv | 5 +
 rtl/wbr_2_cell.sv | 18 +
 rtl/wbr_2.sv | 56 +++++
 tb/tb_wbr_2.sv | 131 +++++++++++++
 4 files changed

// File: rtl/wbr_2_pkg.sv
// wbr_2_pkg: shared constants for the wbr_2 input wrapper boundary register.
package wbr_2_pkg;
    localparam int WBR2_LEN = 9;
    localparam int ADDR_W   = 6;
endpackage

// File: rtl/wbr_2_cell.sv
// wbr_cell: one wrapper boundary cell, a shift/capture storage flop plus a core-side hold mux.
// Ports: clk/resetn clock and async active-low reset; se shift enable; si chain input;
//        fi functional input; hold core-side select; q flop value; co core-side value.
module wbr_cell (
    input  logic clk,
    input  logic resetn,
    input  logic se,
    input  logic si,
    input  logic fi,
    input  logic hold,
    output logic q,
    output logic co
);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) q <= 1'b0;
        else         q <= se ? si : fi;
    assign co = hold ? q : fi;
endmodule

// File: rtl/wbr_2.sv
// wbr_2: 9-cell input wrapper boundary register (WPSI2 -> MBISTDLOG .. RESET -> WPSO2).
// Ports: resetn async active-low reset; wse_inputs shift(1)/capture(0); hold_inputs core
//        select (1 = cell, 0 = pass-through); CLK wrapper clock; MBISTDLOG, MBISTRUN, ADDR,
//        RESET functional inputs; WPSI2 scan in; WPSO2 scan out; CoreIN_* core-side values;
//        cell_MBISTRUN / cell_MBISTDLOG raw cell flop values.
module wbr_2
    import wbr_2_pkg::*;
(
    input  logic              resetn,
    input  logic              wse_inputs,
    input  logic              hold_inputs,
    input  logic              CLK,
    input  logic              MBISTDLOG,
    input  logic              MBISTRUN,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              RESET,
    input  logic              WPSI2,
    output logic              WPSO2,
    output logic              CoreIN_MBISTDLOG,
    output logic              CoreIN_MBISTRUN,
    output logic [ADDR_W-1:0] CoreIN_ADDR,
    output logic              CoreIN_RESET,
    output logic              cell_MBISTRUN,
    output logic              cell_MBISTDLOG
);
    // Bit index runs from the chain head (bit 8, MBISTDLOG) down to the tail (bit 0, RESET),
    // so each cell's predecessor is simply the next-higher bit.
    logic [WBR2_LEN-1:0] func, si, q, co;

    assign func = {MBISTDLOG, MBISTRUN, ADDR, RESET};
    assign si   = {WPSI2, q[WBR2_LEN-1:1]};

    genvar i;
    generate
        for (i = 0; i < WBR2_LEN; i++) begin : g_cell
            wbr_cell u_cell (
                .clk    (CLK),
                .resetn (resetn),
                .se     (wse_inputs),
                .si     (si[i]),
                .fi     (func[i]),
                .hold   (hold_inputs),
                .q      (q[i]),
                .co     (co[i])
            );
        end
    endgenerate

    assign WPSO2            = q[0];
    assign CoreIN_MBISTDLOG = co[8];
    assign CoreIN_MBISTRUN  = co[7];
    assign CoreIN_ADDR      = co[6:1];
    assign CoreIN_RESET     = co[0];
    assign cell_MBISTRUN    = q[7];
    assign cell_MBISTDLOG   = q[8];
endmodule

// File: tb/tb_wbr_2.sv
// tb_wbr_2: scoreboard bench for wbr_2 against a queue-based chain model.
module tb_wbr_2;
    logic       resetn = 1'b0, wse_inputs = 1'b0, hold_inputs = 1'b1, CLK = 1'b0;
    logic       MBISTDLOG = 1'b0, MBISTRUN = 1'b0, RESET = 1'b0, WPSI2 = 1'b0;
    logic [5:0] ADDR = 6'h0;
    logic       WPSO2, CoreIN_MBISTDLOG, CoreIN_MBISTRUN, CoreIN_RESET;
    logic       cell_MBISTRUN, cell_MBISTDLOG;
    logic [5:0] CoreIN_ADDR;

    wbr_2 dut (
        .resetn           (resetn),
        .wse_inputs       (wse_inputs),
        .hold_inputs      (hold_inputs),
        .CLK              (CLK),
        .MBISTDLOG        (MBISTDLOG),
        .MBISTRUN         (MBISTRUN),
        .ADDR             (ADDR),
        .RESET            (RESET),
        .WPSI2            (WPSI2),
        .WPSO2            (WPSO2),
        .CoreIN_MBISTDLOG (CoreIN_MBISTDLOG),
        .CoreIN_MBISTRUN  (CoreIN_MBISTRUN),
        .CoreIN_ADDR      (CoreIN_ADDR),
        .CoreIN_RESET     (CoreIN_RESET),
        .cell_MBISTRUN    (cell_MBISTRUN),
        .cell_MBISTDLOG   (cell_MBISTDLOG)
    );

    always #10 CLK = ~CLK;

    typedef struct {
        logic [11:0] v;
        int          phase;
    } exp_t;

    exp_t exp_q[$];
    logic m[$];
    int   total = 0, bad = 0, phase = 0;

    // Model: m holds the 9 chain bits in chain order, m[0] = MBISTDLOG cell, m[8] = RESET cell.
    task automatic model_clear();
        m.delete();
        for (int i = 0; i < 9; i++) m.push_back(1'b0);
    endtask

    task automatic model_edge();
        if (wse_inputs) begin
            m.push_front(WPSI2);
            void'(m.pop_back());
        end else begin
            m.delete();
            m.push_back(MBISTDLOG);
            m.push_back(MBISTRUN);
            for (int i = 5; i >= 0; i--) m.push_back(ADDR[i]);
            m.push_back(RESET);
        end
    endtask

    function automatic logic [11:0] expect_now();
        logic [5:0] ca;
        for (int i = 0; i < 6; i++) ca[5-i] = m[2+i];
        return {m[8],
                m[0], m[1],
                hold_inputs ? m[0] : MBISTDLOG,
                hold_inputs ? m[1] : MBISTRUN,
                hold_inputs ? ca   : ADDR,
                hold_inputs ? m[8] : RESET};
    endfunction

    // One clock: the edge applies the previous inputs to the model, then new inputs are driven.
    task automatic step(input logic rn, input logic se, input logic hd, input logic si,
                        input logic dl, input logic rr, input logic [5:0] ad, input logic rs);
        exp_t e;
        @(posedge CLK);
        if (resetn) model_edge();
        #2;
        resetn = rn; wse_inputs = se; hold_inputs = hd; WPSI2 = si;
        MBISTDLOG = dl; MBISTRUN = rr; ADDR = ad; RESET = rs;
        if (!rn) model_clear();
        e.v = expect_now();
        e.phase = phase;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [11:0] act;
            e = exp_q.pop_front();
            act = {WPSO2, cell_MBISTDLOG, cell_MBISTRUN, CoreIN_MBISTDLOG, CoreIN_MBISTRUN,
                   CoreIN_ADDR, CoreIN_RESET};
            total++;
            if (act !== e.v) begin
                bad++;
                $display("FAIL phase%0d outputs t=%0t got=%b want=%b (wpso,cd,cr,dlog,run,addr,rst)",
                         e.phase, $time, act, e.v);
            end
        end
    end

    initial begin
        model_clear();
        phase = 1;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 1, 6'h3F, 1);
        phase = 2;
        for (int i = 0; i < 24; i++) step(1, 1, 1, i[0], 0, 0, 6'h00, 0);
        phase = 3;
        step(1, 0, 1, 0, 0, 1, 6'h2D, 1);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 0, 6'h00, 0);
        phase = 4;
        for (int i = 0; i < 4; i++) step(1, i[0], 0, 1, 1, 0, 6'h15, 0);
        phase = 5;
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0, 0, 6'h00, 0);
        step(0, 1, 1, 1, 0, 0, 6'h00, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 0, 6'h00, 0);
        phase = 6;
        for (int i = 0; i < 300; i++)
            step($urandom_range(31) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 6'($urandom), 1'($urandom));
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
